// File: rtl/decimal_up_timer.sv
// Multi-digit BCD up-counting elapsed-time timer with programmable target,
// wrap-with-carry or saturate-at-all-9s overflow, and pause/resume control.
module decimal_up_timer #(
    parameter int NUM_DIGITS = 2,
    parameter bit WRAP       = 1'b1
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    tick,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    clear,
    input  logic                    loadN,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic [4*NUM_DIGITS-1:0] target,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    running,
    output logic                    done,
    output logic                    carry_out
);

    localparam int W = 4 * NUM_DIGITS;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

    logic [1:0]   state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic         carry_q, carry_d;

    logic [W-1:0] inc_val;
    logic [W-1:0] next_val;
    logic         at_max;
    logic         target_ok;

    // Ripple-carry BCD step: a digit moves only while every lower digit is 9.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        logic         c;
        r = '0;
        c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (d == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    c           = 1'b0;
                end
            end else begin
                r[4*i +: 4] = d;
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d           = v[4*i +: 4];
            r[4*i +: 4] = (d > 4'd9) ? 4'd9 : d;
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    assign inc_val   = bcd_inc(count_q);
    assign at_max    = (count_q == ALL_NINES);
    assign next_val  = (at_max && !WRAP) ? count_q : inc_val;
    assign target_ok = bcd_valid(target);

    always_comb begin
        // NOTE: every variable assigned here gets a default first so no path
        // leaves it unassigned; that is what keeps this block free of latches.
        state_d = state_q;
        count_d = count_q;
        carry_d = 1'b0;

        if (clear) begin
            count_d = '0;
            state_d = ST_IDLE;
        end else if (!loadN) begin
            count_d = bcd_clamp(load_value);
            state_d = ST_IDLE;
        end else if (pause) begin
            if (state_q == ST_RUN) state_d = ST_PAUSE;
        end else if (start && (state_q == ST_IDLE || state_q == ST_PAUSE)) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN && tick) begin
            count_d = next_val;
            // Target match is checked on the value being written, so done and
            // the target count become visible on the same edge.
            if (target_ok && next_val == target) begin
                state_d = ST_DONE;
            end else if (at_max) begin
                if (WRAP) carry_d = 1'b1;
                else      state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its pre-edge inputs, independent of statement order.
        if (!resetN) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            carry_q <= carry_d;
        end
    end

    assign count     = count_q;
    assign running   = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign carry_out = carry_q;

endmodule
